// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory responder: FSM states,
// memory-mapped keyboard/display register addresses and the ready-bit index.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE,
    ST_RELEASE
  } mem_state_e;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;
  localparam int          RDY_BIT   = 15;

  function automatic logic is_mmio(input logic [15:0] addr);
    return (addr == KBSR_ADDR) || (addr == KBDR_ADDR) ||
           (addr == DSR_ADDR)  || (addr == DDR_ADDR);
  endfunction

endpackage

// File: rtl/lc3_mem_ram.sv
// Single-port synchronous RAM of 2^ADDR_W 16-bit words with write enable
// and an enabled, registered read port that holds its last value.
module lc3_mem_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] mem [2**ADDR_W];
  logic [15:0] rdata_q;

  // NOTE: the array itself is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata_q <= '0;
    else if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lc3_memory.sv
// LC-3 memory responder: accepts MAR/MDR requests, inserts WAIT_CYCLES wait
// states and pulses o_R once per request. Define LC3_MEM_MMIO_EN for KBSR/KBDR/DSR/DDR.
module lc3_memory
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 3
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_MEM_EN,
  input  logic        i_R_W,
  input  logic [15:0] i_MAR,
  input  logic [15:0] i_MDR,
  output logic [15:0] o_Data,
  output logic        o_R,
  input  logic        i_Kbd_Valid,
  input  logic [7:0]  i_Kbd_Char,
  output logic        o_Dsp_Valid,
  output logic [7:0]  o_Dsp_Char,
  input  logic        i_Dsp_Ack
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  mem_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rw_q, rw_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;

  logic        accept, done, rd_enter, acc_rw;
  logic [15:0] acc_addr, ram_rdata;
  logic        ram_we, ram_re;

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // NOTE: every combinational output is defaulted first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      ST_IDLE: if (i_MEM_EN) begin
        rw_d    = i_R_W;
        addr_d  = i_MAR;
        wdata_d = i_MDR;
        cnt_d   = WAIT_INIT;
        state_d = (WAIT_CYCLES == 0) ? ST_DONE : ST_BUSY;
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_DONE;
      end
      ST_DONE:    state_d = ST_RELEASE;
      ST_RELEASE: if (!i_MEM_EN) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // The access being completed uses the live request on the accept edge when there are no wait states.
  always_comb begin
    accept   = (state_q == ST_IDLE) && i_MEM_EN;
    done     = (state_q == ST_DONE);
    acc_rw   = accept ? i_R_W : rw_q;
    acc_addr = accept ? i_MAR : addr_q;
    rd_enter = (state_d == ST_DONE) && !acc_rw;
  end

  assign o_R = done;

  lc3_mem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (i_Clk),
    .rst_n (i_Rst_n),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (acc_addr[ADDR_W-1:0]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

`ifdef LC3_MEM_MMIO_EN
  logic        kbsr_q, kbsr_d, dsr_q, dsr_d;
  logic        dsp_valid_q, dsp_valid_d, mmio_sel_q, mmio_sel_d;
  logic [7:0]  kbdr_q, kbdr_d, dsp_char_q, dsp_char_d;
  logic [15:0] mmio_rdata_q, mmio_rdata_d;
  logic        kbdr_rd_done, ddr_wr_done;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      kbsr_q       <= 1'b0;
      kbdr_q       <= '0;
      dsr_q        <= 1'b1;
      dsp_valid_q  <= 1'b0;
      dsp_char_q   <= '0;
      mmio_sel_q   <= 1'b0;
      mmio_rdata_q <= '0;
    end else begin
      kbsr_q       <= kbsr_d;
      kbdr_q       <= kbdr_d;
      dsr_q        <= dsr_d;
      dsp_valid_q  <= dsp_valid_d;
      dsp_char_q   <= dsp_char_d;
      mmio_sel_q   <= mmio_sel_d;
      mmio_rdata_q <= mmio_rdata_d;
    end
  end

  always_comb begin
    kbsr_d       = kbsr_q;
    kbdr_d       = kbdr_q;
    dsr_d        = dsr_q;
    dsp_char_d   = dsp_char_q;
    mmio_sel_d   = mmio_sel_q;
    mmio_rdata_d = mmio_rdata_q;
    kbdr_rd_done = done && !rw_q && (addr_q == KBDR_ADDR);
    ddr_wr_done  = done &&  rw_q && (addr_q == DDR_ADDR);
    dsp_valid_d  = ddr_wr_done;

    // A keystroke arriving on the same edge the KBDR read clears ready is kept.
    if (i_Kbd_Valid && (!kbsr_q || kbdr_rd_done)) begin
      kbdr_d = i_Kbd_Char;
      kbsr_d = 1'b1;
    end else if (kbdr_rd_done) begin
      kbsr_d = 1'b0;
    end

    if (ddr_wr_done) begin
      dsp_char_d = wdata_q[7:0];
      dsr_d      = 1'b0;
    end else if (i_Dsp_Ack) begin
      dsr_d = 1'b1;
    end

    if (rd_enter) begin
      mmio_sel_d   = is_mmio(acc_addr);
      mmio_rdata_d = '0;
      case (acc_addr)
        KBSR_ADDR: mmio_rdata_d[RDY_BIT] = kbsr_q;
        KBDR_ADDR: mmio_rdata_d          = {8'h00, kbdr_q};
        DSR_ADDR:  mmio_rdata_d[RDY_BIT] = dsr_q;
        default:   mmio_rdata_d          = '0;
      endcase
    end
  end

  assign ram_re      = rd_enter && !is_mmio(acc_addr);
  assign ram_we      = done && rw_q && !is_mmio(addr_q);
  assign o_Data      = mmio_sel_q ? mmio_rdata_q : ram_rdata;
  assign o_Dsp_Valid = dsp_valid_q;
  assign o_Dsp_Char  = dsp_char_q;
`else
  logic unused_inputs;

  assign unused_inputs = ^{i_Kbd_Valid, i_Kbd_Char, i_Dsp_Ack, acc_addr[15:ADDR_W]};
  assign ram_re        = rd_enter;
  assign ram_we        = done && rw_q;
  assign o_Data        = ram_rdata;
  assign o_Dsp_Valid   = 1'b0;
  assign o_Dsp_Char    = '0;
`endif

endmodule
